// File: rtl/pagerank_pkg.sv
// Shared types and helpers for the pagerank gather/apply stage.
package pagerank_pkg;

  localparam int unsigned RANK_W_DEF = 32;
  localparam int unsigned FRAC_W     = 30;

  typedef logic [RANK_W_DEF-1:0] rank_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATHER = 2'd1,
    APPLY  = 2'd2,
    DONE   = 2'd3
  } gather_state_e;

  // Unsigned add clamped to the largest value representable in w bits (w <= 64).
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [63:0] max_v;
    max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    sum   = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_v}) ? max_v : sum[63:0];
  endfunction

endpackage

// File: rtl/pr_apply_unit.sv
// Damping datapath for one node: new = base + (acc*d >> 16) saturated, plus |new - old|.
module pr_apply_unit
  import pagerank_pkg::*;
#(
  parameter int unsigned RANK_W = 32
) (
  input  logic [RANK_W-1:0] acc,
  input  logic [RANK_W-1:0] rank_old,
  input  logic [RANK_W-1:0] base_term,
  input  logic [15:0]       damping_q16,
  output logic [RANK_W-1:0] new_rank,
  output logic [RANK_W-1:0] delta
);

  localparam int unsigned PROD_W = RANK_W + 16;

  logic [PROD_W-1:0] prod;
  logic [RANK_W-1:0] scaled;

  always_comb begin
    prod     = PROD_W'(acc) * PROD_W'(damping_q16);
    scaled   = RANK_W'(prod >> 16);
    new_rank = RANK_W'(sat_add(64'(base_term), 64'(scaled), RANK_W));
    delta    = (new_rank >= rank_old) ? (new_rank - rank_old) : (rank_old - new_rank);
  end

endmodule

// File: rtl/pagerank_gather_apply.sv
// Pagerank gather/apply stage: per-node accumulation of streamed contributions, damping, convergence tracking.
// Define PR_GATHER_L1_NORM_EN to use the saturating L1 norm of node deltas as the metric instead of the max.
module pagerank_gather_apply
  import pagerank_pkg::*;
#(
  parameter int unsigned NUM_NODES = 4,
  parameter int unsigned RANK_W    = 32,
  parameter int unsigned MAX_ITERS = 64
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [RANK_W-1:0]            init_rank,
  input  logic [RANK_W-1:0]            base_term,
  input  logic [15:0]                  damping_q16,
  input  logic [RANK_W-1:0]            threshold,
  input  logic                         upd_valid,
  output logic                         upd_ready,
  input  logic [$clog2(NUM_NODES)-1:0] upd_dest,
  input  logic [RANK_W-1:0]            upd_contrib,
  input  logic                         upd_last,
  input  logic [$clog2(NUM_NODES)-1:0] rank_rd_addr,
  output logic [RANK_W-1:0]            rank_rd_data,
  output logic                         iter_done,
  output logic [15:0]                  iter_count,
  output logic                         converged,
  output logic                         busy
);

  localparam int unsigned ADDR_W = $clog2(NUM_NODES);
  localparam int unsigned K_W    = $clog2(NUM_NODES + 1);

  gather_state_e     state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [RANK_W-1:0] metric_q, metric_d, metric_next;
  logic [RANK_W-1:0] acc_q  [NUM_NODES];
  logic [RANK_W-1:0] acc_d  [NUM_NODES];
  logic [RANK_W-1:0] rank_q [NUM_NODES];
  logic [RANK_W-1:0] rank_d [NUM_NODES];

  logic              upd_ready_q, upd_ready_d;
  logic              iter_done_q, iter_done_d;
  logic [15:0]       iter_count_q, iter_count_d;
  logic              converged_q, converged_d;
  logic              busy_q, busy_d;
  logic [RANK_W-1:0] rank_rd_data_q, rank_rd_data_d;

  logic [RANK_W-1:0] acc_sel, rank_sel, new_rank, delta;
  logic              xfer;

  assign xfer = upd_valid && upd_ready_q;

  // Operand select for the node currently being applied, and the read-port mux.
  always_comb begin
    acc_sel        = '0;
    rank_sel       = '0;
    rank_rd_data_d = '0;
    for (int i = 0; i < int'(NUM_NODES); i++) begin
      if (k_q == K_W'(i)) begin
        acc_sel  = acc_q[i];
        rank_sel = rank_q[i];
      end
      if (rank_rd_addr == ADDR_W'(i)) begin
        rank_rd_data_d = rank_q[i];
      end
    end
  end

  pr_apply_unit #(
    .RANK_W (RANK_W)
  ) u_apply (
    .acc         (acc_sel),
    .rank_old    (rank_sel),
    .base_term   (base_term),
    .damping_q16 (damping_q16),
    .new_rank    (new_rank),
    .delta       (delta)
  );

  always_comb begin
`ifdef PR_GATHER_L1_NORM_EN
    metric_next = RANK_W'(sat_add(64'(metric_q), 64'(delta), RANK_W));
`else
    metric_next = (delta > metric_q) ? delta : metric_q;
`endif
  end

  // Next-state and register-input logic.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    metric_d     = metric_q;
    acc_d        = acc_q;
    rank_d       = rank_q;
    iter_done_d  = 1'b0;
    iter_count_d = iter_count_q;
    converged_d  = converged_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          for (int i = 0; i < int'(NUM_NODES); i++) begin
            rank_d[i] = init_rank;
            acc_d[i]  = '0;
          end
          iter_count_d = '0;
          converged_d  = 1'b0;
          metric_d     = '0;
          k_d          = '0;
          state_d      = GATHER;
        end
      end

      GATHER: begin
        // Accumulators are flops, so a same-dest update next cycle already sees this sum.
        if (xfer) begin
          for (int i = 0; i < int'(NUM_NODES); i++) begin
            if (upd_dest == ADDR_W'(i)) begin
              acc_d[i] = RANK_W'(sat_add(64'(acc_q[i]), 64'(upd_contrib), RANK_W));
            end
          end
          if (upd_last) begin
            state_d = APPLY;
            k_d     = '0;
          end
        end
      end

      APPLY: begin
        if (k_q != K_W'(NUM_NODES)) begin
          for (int i = 0; i < int'(NUM_NODES); i++) begin
            if (k_q == K_W'(i)) begin
              rank_d[i] = new_rank;
              acc_d[i]  = '0;
            end
          end
          metric_d = metric_next;
          k_d      = k_q + K_W'(1);
          // Results land in the trailing cycle, which then picks the exit state.
          if (k_q == K_W'(NUM_NODES - 1)) begin
            iter_done_d  = 1'b1;
            iter_count_d = iter_count_q + 16'd1;
            converged_d  = (metric_next <= threshold);
            metric_d     = '0;
          end
        end else begin
          state_d = (converged_q || (iter_count_q >= 16'(MAX_ITERS))) ? DONE : GATHER;
        end
      end

      default: state_d = IDLE;
    endcase

    upd_ready_d = (state_d == GATHER);
    busy_d      = (state_d == GATHER) || (state_d == APPLY);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      k_q            <= '0;
      metric_q       <= '0;
      acc_q          <= '{default: '0};
      rank_q         <= '{default: '0};
      upd_ready_q    <= 1'b0;
      iter_done_q    <= 1'b0;
      iter_count_q   <= '0;
      converged_q    <= 1'b0;
      busy_q         <= 1'b0;
      rank_rd_data_q <= '0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      metric_q       <= metric_d;
      acc_q          <= acc_d;
      rank_q         <= rank_d;
      upd_ready_q    <= upd_ready_d;
      iter_done_q    <= iter_done_d;
      iter_count_q   <= iter_count_d;
      converged_q    <= converged_d;
      busy_q         <= busy_d;
      rank_rd_data_q <= rank_rd_data_d;
    end
  end

  assign upd_ready    = upd_ready_q;
  assign iter_done    = iter_done_q;
  assign iter_count   = iter_count_q;
  assign converged    = converged_q;
  assign busy         = busy_q;
  assign rank_rd_data = rank_rd_data_q;

endmodule

// File: tb/tb_pagerank_gather_apply.sv
// Bench for pagerank_gather_apply: directed vector table, hand-written corner sequences, randomized model runs.
module tb_pagerank_gather_apply;

  localparam int     N    = 4;
  localparam longint MAXV = 64'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset, start, upd_valid, upd_last;
  logic [31:0] init_rank, base_term, threshold, upd_contrib;
  logic [15:0] damping_q16;
  logic [1:0]  upd_dest, rank_rd_addr;

  logic        upd_ready, iter_done, converged, busy;
  logic [15:0] iter_count;
  logic [31:0] rank_rd_data;
  logic        cap_upd_ready, cap_iter_done, cap_converged, cap_busy;
  logic [15:0] cap_iter_count;
  logic [31:0] cap_rank_rd_data;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cap_pulses = 0;

  pagerank_gather_apply dut (
    .clock(clock), .reset(reset), .start(start), .init_rank(init_rank),
    .base_term(base_term), .damping_q16(damping_q16), .threshold(threshold),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_dest(upd_dest),
    .upd_contrib(upd_contrib), .upd_last(upd_last), .rank_rd_addr(rank_rd_addr),
    .rank_rd_data(rank_rd_data), .iter_done(iter_done), .iter_count(iter_count),
    .converged(converged), .busy(busy)
  );

  pagerank_gather_apply #(.MAX_ITERS(3)) dut_cap (
    .clock(clock), .reset(reset), .start(start), .init_rank(init_rank),
    .base_term(base_term), .damping_q16(damping_q16), .threshold(threshold),
    .upd_valid(upd_valid), .upd_ready(cap_upd_ready), .upd_dest(upd_dest),
    .upd_contrib(upd_contrib), .upd_last(upd_last), .rank_rd_addr(rank_rd_addr),
    .rank_rd_data(cap_rank_rd_data), .iter_done(cap_iter_done), .iter_count(cap_iter_count),
    .converged(cap_converged), .busy(cap_busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (cap_iter_done) cap_pulses = cap_pulses + 1;

  typedef struct {
    logic [31:0] init_r;
    logic [31:0] base;
    logic [15:0] damp;
    logic [31:0] thr;
    int          n_upd;
    logic [1:0]  dest     [4];
    logic [31:0] contrib  [4];
    logic [31:0] exp_rank [4];
    logic        exp_conv;
  } vec_t;

  vec_t vecs [3];

  longint m_rank [N];
  longint m_acc  [N];
  int     m_iters;

  logic [31:0] v;
  bit          mconv;
  int          cnt, pulses0, nupd;

  task automatic chk(input string name, input longint got, input longint exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; upd_valid = 1'b0; upd_last = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic set_cfg(input logic [31:0] ir, input logic [31:0] b, input logic [15:0] d,
                         input logic [31:0] t);
    init_rank = ir; base_term = b; damping_q16 = d; threshold = t;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [1:0] d, input logic [31:0] c, input logic last);
    int t = 0;
    upd_valid = 1'b1; upd_dest = d; upd_contrib = c; upd_last = last;
    while (!upd_ready && t < 50) begin step(); t++; end
    chk("send_ready_wait", upd_ready, 1);
    step();
    upd_valid = 1'b0; upd_last = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!iter_done && t < 40) begin step(); t++; end
    chk("iter_done_wait", iter_done, 1);
  endtask

  task automatic rd(input int i, output logic [31:0] val);
    rank_rd_addr = 2'(i);
    step();
    val = rank_rd_data;
  endtask

  // Reference: add to an accumulator with clamping at the 32-bit maximum.
  task automatic model_update(input int d, input longint c);
    m_acc[d] = (m_acc[d] + c > MAXV) ? MAXV : m_acc[d] + c;
  endtask

  // Reference: one full apply pass over all nodes, returns the convergence verdict.
  task automatic model_apply(input longint b, input longint d, input longint t, output bit conv);
    longint metric, nw, dl;
    metric = 0;
    for (int k = 0; k < N; k++) begin
      nw = b + (m_acc[k] * d) / 65536;
      if (nw > MAXV) nw = MAXV;
      dl = (nw > m_rank[k]) ? nw - m_rank[k] : m_rank[k] - nw;
`ifdef PR_GATHER_L1_NORM_EN
      metric = (metric + dl > MAXV) ? MAXV : metric + dl;
`else
      if (dl > metric) metric = dl;
`endif
      m_rank[k] = nw;
      m_acc[k]  = 0;
    end
    m_iters++;
    conv = (metric <= t);
  endtask

  initial begin
    start = 0; upd_valid = 0; upd_last = 0; upd_dest = 0; upd_contrib = 0; rank_rd_addr = 0;
    set_cfg(0, 0, 0, 0);

    // Directed vectors: steady state, hot node, saturation.
    vecs[0].init_r = 32'd268435456; vecs[0].base = 32'd40265318; vecs[0].damp = 16'd55706;
    vecs[0].thr = 32'd10737; vecs[0].n_upd = 4;
    vecs[0].dest = '{2'd0, 2'd1, 2'd2, 2'd3};
    vecs[0].contrib = '{32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000};
    vecs[0].exp_rank = '{32'd268437094, 32'd268437094, 32'd268437094, 32'd268437094};
    vecs[0].exp_conv = 1'b1;

    vecs[1].init_r = 32'd268435456; vecs[1].base = 32'd40265318; vecs[1].damp = 16'd55706;
    vecs[1].thr = 32'd0; vecs[1].n_upd = 3;
    vecs[1].dest = '{2'd2, 2'd2, 2'd2, 2'd0};
    vecs[1].contrib = '{32'h0800_0000, 32'h0800_0000, 32'h0800_0000, 32'd0};
    vecs[1].exp_rank = '{32'd40265318, 32'd40265318, 32'd382522982, 32'd40265318};
    vecs[1].exp_conv = 1'b0;

    vecs[2].init_r = 32'd268435456; vecs[2].base = 32'h4000_0000; vecs[2].damp = 16'd55706;
    vecs[2].thr = 32'd0; vecs[2].n_upd = 2;
    vecs[2].dest = '{2'd0, 2'd0, 2'd0, 2'd0};
    vecs[2].contrib = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    vecs[2].exp_rank = '{32'hFFFF_FFFF, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000};
    vecs[2].exp_conv = 1'b0;

    do_reset();
    chk("rst_upd_ready", upd_ready, 0);
    chk("rst_iter_done", iter_done, 0);
    chk("rst_iter_count", iter_count, 0);
    chk("rst_converged", converged, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_data", rank_rd_data, 0);

    for (int t = 0; t < 3; t++) begin
      do_reset();
      set_cfg(vecs[t].init_r, vecs[t].base, vecs[t].damp, vecs[t].thr);
      pulse_start();
      chk("vec_busy_gather", busy, 1);
      for (int u = 0; u < vecs[t].n_upd; u++)
        send(vecs[t].dest[u], vecs[t].contrib[u], u == vecs[t].n_upd - 1);
      wait_done();
      chk("vec_iter_count", iter_count, 1);
      chk("vec_converged", converged, vecs[t].exp_conv);
      step();
      chk("vec_busy_after", busy, !vecs[t].exp_conv);
      chk("vec_ready_after", upd_ready, !vecs[t].exp_conv);
      for (int i = 0; i < N; i++) begin
        rd(i, v);
        chk("vec_rank", v, vecs[t].exp_rank[i]);
      end
    end

    // Backpressure: valid held high through APPLY.
    do_reset();
    set_cfg(32'd268435456, 32'd40265318, 16'd55706, 32'd0);
    pulse_start();
    for (int u = 0; u < 3; u++) send(2'(u), 32'h1000_0000, 1'b0);
    upd_valid = 1'b1; upd_dest = 2'd3; upd_contrib = 32'h1000_0000; upd_last = 1'b1;
    chk("bp_ready_before_last", upd_ready, 1);
    step();
    upd_dest = 2'd1; upd_contrib = 32'h0400_0000; upd_last = 1'b0;
    cnt = 0;
    while (!upd_ready && cnt < 20) begin cnt++; step(); end
    chk("bp_ready_low_cycles", cnt, N + 1);
    step();
    upd_valid = 1'b0;
    send(2'd1, 32'h0400_0000, 1'b1);
    wait_done();
    chk("bp_iter_count", iter_count, 2);
    step();
    rd(1, v); chk("bp_rank1", v, 32'd154351206);
    rd(0, v); chk("bp_rank0", v, 32'd40265318);

    // Reset in the middle of APPLY.
    do_reset();
    pulse_start();
    for (int u = 0; u < N; u++) send(2'(u), 32'h1000_0000, u == N - 1);
    wait_done();
    step();
    for (int u = 0; u < N; u++) send(2'(u), 32'h0200_0000, u == N - 1);
    step(); step();
    reset = 1'b1;
    step();
    chk("mid_rst_upd_ready", upd_ready, 0);
    chk("mid_rst_iter_done", iter_done, 0);
    chk("mid_rst_iter_count", iter_count, 0);
    chk("mid_rst_converged", converged, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd_data", rank_rd_data, 0);
    reset = 1'b0;
    rd(2, v); chk("mid_rst_rank2", v, 0);
    set_cfg(32'd268435456, 32'd40265318, 16'd55706, 32'd10737);
    pulse_start();
    for (int u = 0; u < N; u++) send(2'(u), 32'h1000_0000, u == N - 1);
    wait_done();
    chk("fresh_iter_count", iter_count, 1);
    chk("fresh_converged", converged, 1);
    step();
    rd(2, v); chk("fresh_rank2", v, 32'd268437094);

    // Iteration cap on the MAX_ITERS=3 instance.
    do_reset();
    set_cfg(32'd268435456, 32'd40265318, 16'd55706, 32'd0);
    pulses0 = cap_pulses;
    pulse_start();
    for (int it = 0; it < 3; it++) begin
      for (int u = 0; u < N; u++)
        send(2'(u), (it % 2 == 1) ? 32'h2000_0000 : 32'h1000_0000, u == N - 1);
      wait_done();
      step();
    end
    chk("cap_iter_count", cap_iter_count, 3);
    chk("cap_converged", cap_converged, 0);
    chk("cap_busy", cap_busy, 0);
    chk("cap_upd_ready", cap_upd_ready, 0);
    chk("cap_default_still_busy", busy, 1);
    for (int i = 0; i < 6; i++) step();
    chk("cap_pulses", cap_pulses - pulses0, 3);

    // Randomized runs against the reference model.
    for (int run = 0; run < 4; run++) begin
      do_reset();
      set_cfg($urandom_range(0, 32'h3FFF_FFFF), $urandom_range(0, 32'h1000_0000),
              16'($urandom), ($urandom_range(0, 1) == 1) ? $urandom_range(0, 32'h3FFF_FFFF)
                                                         : $urandom_range(0, 4096));
      for (int i = 0; i < N; i++) begin m_rank[i] = longint'(init_rank); m_acc[i] = 0; end
      m_iters = 0;
      pulse_start();
      for (int it = 0; it < 5; it++) begin
        nupd = $urandom_range(1, 6);
        for (int u = 0; u < nupd; u++) begin
          int dd;
          logic [31:0] cc;
          dd = $urandom_range(0, N - 1);
          cc = ($urandom_range(0, 7) == 0) ? 32'hF000_0000 : $urandom_range(0, 32'h2000_0000);
          model_update(dd, longint'(cc));
          send(2'(dd), cc, u == nupd - 1);
          for (int g = $urandom_range(0, 2); g > 0; g--) step();
        end
        model_apply(longint'(base_term), longint'(damping_q16), longint'(threshold), mconv);
        wait_done();
        chk("rnd_iter_count", iter_count, m_iters);
        chk("rnd_converged", converged, mconv);
        step();
        chk("rnd_busy", busy, !mconv);
        for (int i = 0; i < N; i++) begin
          rd(i, v);
          chk("rnd_rank", v, m_rank[i]);
        end
        if (mconv) break;
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pagerank_gather_apply.md
Name: pagerank_gather_apply

Overview:
- Gather/apply stage directly downstream of the pagerank scatter threads.
- Consumes streamed (dest, contribution) updates, accumulates per-node sums, then applies damping: rank = base + d*sum.
- Tracks per-node |delta| against the threshold and reports convergence. Exposes a registered read port so scatter can fetch current ranks for the next iteration.
- Synthesizable fixed-point; real-typed models stay in benches.

Parameters:
- NUM_NODES, 4, nodes in the graph (>=2).
- RANK_W, 32, rank/contribution width, unsigned Q2.30 (range [0,4)).
- MAX_ITERS, 64, iteration cap; DONE is forced when reached.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- start  in  1  pulse; loads init_rank into all nodes and enters GATHER.
- init_rank  in  RANK_W  initial rank, Q2.30.
- base_term  in  RANK_W  (1-d)/N, Q2.30, precomputed.
- damping_q16  in  16  d in Q0.16.
- threshold  in  RANK_W  convergence threshold, Q2.30.
- upd_valid  in  1  update present.
- upd_ready  out  1  stage accepts an update.
- upd_dest  in  $clog2(NUM_NODES)  destination node.
- upd_contrib  in  RANK_W  rank/out_degree contribution, Q2.30.
- upd_last  in  1  final update of this iteration (qualified by upd_valid).
- rank_rd_addr  in  $clog2(NUM_NODES)  read address.
- rank_rd_data  out  RANK_W  rank[rank_rd_addr], registered, 1-cycle latency.
- iter_done  out  1  one-cycle pulse at the end of each APPLY.
- iter_count  out  16  completed iterations.
- converged  out  1  last completed iteration met the threshold.
- busy  out  1  state != IDLE && state != DONE.

Behaviour:
- Reset:
  - State IDLE. upd_ready=0, iter_done=0, iter_count=0, converged=0, busy=0, rank_rd_data=0.
  - acc[] and rank[] cleared.
  - Reset mid-operation aborts immediately with the same values.
- State IDLE:
  - start: rank[i]=init_rank, acc[i]=0, iter_count=0, converged=0, then go to GATHER.
  - Any other input is ignored.
- State GATHER:
  - upd_ready=1. A transfer occurs when upd_valid && upd_ready.
  - Transfer: acc[upd_dest] += upd_contrib, saturating at 2^RANK_W-1.
  - Back-to-back updates to the same dest every cycle must all be counted; implement with a read-modify-write bypass.
  - A transfer with upd_last=1 is accumulated, then the state moves to APPLY. upd_ready drops the next cycle.
- State APPLY (upd_ready=0):
  - Index k runs 0..NUM_NODES-1, one node per cycle.
  - new = base_term + ((acc[k]*damping_q16)>>16). 48-bit product, truncating shift, saturating add.
  - delta = |new - rank[k]|. Write rank[k]=new and acc[k]=0.
  - Running metric = max(delta).
  - After the last node, on the next cycle: iter_done=1 for one cycle, iter_count+=1, converged=(metric<=threshold).
  - APPLY therefore lasts NUM_NODES+1 cycles.
  - If converged or iter_count==MAX_ITERS, go to DONE; otherwise go to GATHER.
- State DONE:
  - Outputs held. start restarts as from IDLE.
- Read port:
  - Valid in every state.
  - During APPLY a read of node k in the cycle it is written returns the old value.
- start while busy is ignored.
- upd_dest >= NUM_NODES: the update is accepted and dropped; no array write.

Optional Feature:
- Macro PR_GATHER_L1_NORM_EN.
- Defined: the metric is the saturating sum of |delta| over all nodes (L1 norm) instead of the max.
- Undefined: the metric is the max |delta|.
- Ports and timing are identical either way.

Decomposition:
- Package pagerank_pkg:
  - rank_t (logic [31:0], Q2.30), FRAC_W=30.
  - gather_state_e {IDLE, GATHER, APPLY, DONE}.
  - Saturating add function.
- Sub-module pr_apply_unit (combinational): inputs acc, rank_old, base_term, damping_q16; outputs new_rank, delta.

Test Plan:
- Steady state, N=4, init_rank=268435456 (0.25), base_term=40265318, damping_q16=55706, threshold=10737. Send 4 updates of 0x10000000, one per node, last on the 4th. Expect rank[i]=268437094, iter_done pulse, iter_count=1, converged=1, state DONE.
- Hot-node accumulation: 3 consecutive same-cycle-stream updates of 0x08000000 to node 2, upd_last on the 3rd. Expect acc 0x18000000 and rank[2]=40265318+((0x18000000*55706)>>16). Non-converging threshold=0 returns to GATHER.
- Backpressure: upd_valid held high through APPLY. upd_ready=0 for exactly NUM_NODES+1 cycles and no update is lost; the held update is accepted on re-entering GATHER.
- Iteration cap: MAX_ITERS=3, threshold=0, alternating contributions. Exactly 3 iter_done pulses, iter_count=3, converged=0, DONE.
- Reset mid-APPLY at k=2: next cycle IDLE, all outputs zero. A subsequent start behaves as a fresh run.
- Saturation: upd_contrib=0xFFFFFFFF twice to node 0. acc saturates; rank[0]=0xFFFFFFFF after apply (saturating add), no wrap.
